// File: rtl/lcd_value_formatter_if.sv
// Handshake bundle between the value source, lcd_value_formatter and lcd_module.
// master: the side that offers values and reports sendingDone; slave: the formatter.
interface lcd_value_formatter_if;
    logic          value_valid;
    logic [15:0]   value;
    logic          sendingDone;
    logic [8*16:1] line1;
    logic [8*16:1] line2;
    logic          sendText;
    logic          busy;

    modport master (
        output value_valid, value, sendingDone,
        input  line1, line2, sendText, busy
    );

    modport slave (
        input  value_valid, value, sendingDone,
        output line1, line2, sendText, busy
    );
endinterface

// File: rtl/lcd_value_formatter.sv
// Converts 16-bit values to a decimal/hex display line with a sequential double-dabble
// and hands both lines to lcd_module; values arriving mid-update are coalesced.
//
// state     | meaning
// IDLE      | waiting for a pending value
// CONVERT   | 16 double-dabble shift cycles
// FORMAT    | latch line2 from the BCD result
// SEND      | one-cycle sendText request
// WAIT_DONE | wait for a sendingDone rising edge
module lcd_value_formatter #(
    parameter logic [8*16:1] LABEL  = "Value:          ",
    parameter bit            HEX_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET,
    lcd_value_formatter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CONVERT, FORMAT, SEND, WAIT_DONE} state_t;

    localparam logic [8*16:1] SPACES = {16{8'h20}};

    state_t        state, state_nx;
    logic [15:0]   pend_val;
    logic          pend_valid;
    logic          sd_q;
    logic [15:0]   bin;
    logic [15:0]   val_q;
    logic [19:0]   bcd;
    logic [19:0]   bcd_adj;
    logic [35:0]   shifted;
    logic [3:0]    cnt;
    logic [8*16:1] line2_q;
    logic [8*16:1] line2_nx;
    logic          launch;
    logic          sd_rise;
    logic          lead;
    logic [3:0]    digit;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n <= 4'd9) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    assign launch  = (state == IDLE) && pend_valid;
    assign sd_rise = bus.sendingDone && !sd_q;
    assign shifted = {bcd_adj, bin} << 1;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (pend_valid) state_nx = CONVERT;
            CONVERT:   if (cnt == 4'd15) state_nx = FORMAT;
            FORMAT:    state_nx = SEND;
            SEND:      state_nx = WAIT_DONE;
            WAIT_DONE: if (sd_rise) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Leading zeros of the four upper decimal digits are blanked; the units digit always shows.
    always_comb begin
        line2_nx = SPACES;
        lead     = 1'b1;
        digit    = 4'd0;
        for (int i = 0; i < 4; i++) begin
            digit = bcd[19-4*i -: 4];
            if (digit != 4'd0) lead = 1'b0;
            if (!lead) line2_nx[128-8*i -: 8] = {4'h3, digit};
        end
        line2_nx[96:89] = {4'h3, bcd[3:0]};
        if (HEX_EN) begin
            line2_nx[56:49] = 8'h30;
            line2_nx[48:41] = 8'h78;
            line2_nx[40:33] = hex_char(val_q[15:12]);
            line2_nx[32:25] = hex_char(val_q[11:8]);
            line2_nx[24:17] = hex_char(val_q[7:4]);
            line2_nx[16:9]  = hex_char(val_q[3:0]);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            pend_val   <= 16'd0;
            pend_valid <= 1'b0;
            sd_q       <= 1'b0;
            bin        <= 16'd0;
            val_q      <= 16'd0;
            bcd        <= 20'd0;
            cnt        <= 4'd0;
            line2_q    <= SPACES;
        end else begin
            state <= state_nx;
            sd_q  <= bus.sendingDone;
            if (bus.value_valid) begin
                pend_val   <= bus.value;
                pend_valid <= 1'b1;
            end else if (launch) begin
                pend_valid <= 1'b0;
            end
            case (state)
                IDLE: if (pend_valid) begin
                    bin   <= pend_val;
                    val_q <= pend_val;
                    bcd   <= 20'd0;
                    cnt   <= 4'd0;
                end
                CONVERT: begin
                    bcd <= shifted[35:16];
                    bin <= shifted[15:0];
                    cnt <= cnt + 4'd1;
                end
                FORMAT:  line2_q <= line2_nx;
                default: ;
            endcase
        end
    end

    assign bus.line1    = LABEL;
    assign bus.line2    = line2_q;
    assign bus.sendText = (state == SEND);
    assign bus.busy     = (state != IDLE);

endmodule
